aurora_nfc_ctrl: RTL and testbench

- Generates Aurora Native Flow Control (NFC) messages that throttle the link partner based on the occupancy of the local RX FIFO behind the Aurora core.
- Sits in the user_clk domain between the RX buffering and the core's NFC AXI4-Stream input.
- Issues XOFF when the fill level reaches a high watermark and XON when it falls to a low watermark (hysteresis).
- Periodically re-sends XOFF while paused, so a lost message cannot leave the partner streaming.
- Suspends all activity while the channel is down.

---
 rtl/aurora_nfc_pkg.sv | 25 ++
 rtl/aurora_nfc_ctrl.sv | 133 +++++++++++++
 tb/tb_aurora_nfc_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/aurora_nfc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aurora_nfc_pkg
// Description : Shared types and NFC message constants for aurora_nfc_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package aurora_nfc_pkg;

    // Controller states; explicit 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_SEND_XOFF = 3'd2,
        ST_PAUSED    = 3'd3,
        ST_SEND_XON  = 3'd4
    } nfc_state_t;

    // NFC message layout: tdata[15:8] pause count, tdata[4] XOFF flag
    localparam int          NFC_XOFF_BIT  = 4;
    localparam int          NFC_PAUSE_LSB = 8;
    localparam logic [15:0] NFC_MSG_XOFF  = 16'h0010;
    localparam logic [15:0] NFC_MSG_XON   = 16'h0000;

endpackage : aurora_nfc_pkg
`default_nettype wire

// File: rtl/aurora_nfc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aurora_nfc_ctrl
// Description : Issues Aurora NFC XOFF/XON messages from RX FIFO occupancy
//               with watermark hysteresis and periodic XOFF refresh.
// Revision    : 1.0 - initial release
// ============================================================================
module aurora_nfc_ctrl
    import aurora_nfc_pkg::*;
#(
    parameter int FIFO_LEVEL_W   = 13,
    parameter int HIGH_WM        = 3072,
    parameter int LOW_WM         = 1024,
    parameter int REFRESH_CYCLES = 4096
) (
    input  logic                    user_clk,
    input  logic                    user_rst_n,
    input  logic                    enable,
    input  logic                    channel_up,
    input  logic [FIFO_LEVEL_W-1:0] rx_fifo_level,
    output logic                    m_axi_nfc_tvalid,
    output logic [15:0]             m_axi_nfc_tdata,
    input  logic                    m_axi_nfc_tready,
    output logic                    xoff_active,
    output logic [15:0]             nfc_msg_count
);

    // Refresh timer sizing; the timer collapses to a single bit when refresh is off
    localparam int                     c_TMR_W      = (REFRESH_CYCLES > 0) ? $clog2(REFRESH_CYCLES + 1) : 1;
    localparam bit                     c_REFRESH_EN = (REFRESH_CYCLES != 0);
    localparam logic [c_TMR_W-1:0]     c_TMR_LAST   = c_REFRESH_EN ? c_TMR_W'(REFRESH_CYCLES - 1) : '0;
    localparam logic [FIFO_LEVEL_W-1:0] c_HIGH_WM   = FIFO_LEVEL_W'(HIGH_WM);
    localparam logic [FIFO_LEVEL_W-1:0] c_LOW_WM    = FIFO_LEVEL_W'(LOW_WM);

    // Reject watermark settings that would break the hysteresis band
    if ((LOW_WM >= HIGH_WM) || (HIGH_WM > (1 << (FIFO_LEVEL_W - 1)))) begin : g_bad_params
        $error("aurora_nfc_ctrl: require LOW_WM < HIGH_WM <= 2**(FIFO_LEVEL_W-1)");
    end

    nfc_state_t           r_state;
    nfc_state_t           w_next_state;
    logic                 r_above_hi;
    logic                 r_below_lo;
    logic [c_TMR_W-1:0]   r_timer;
    logic                 w_expire;
    logic                 w_handshake;
    logic                 r_tvalid;
    logic [15:0]          r_tdata;
    logic                 r_xoff;
    logic [15:0]          r_count;

    assign w_handshake = r_tvalid && m_axi_nfc_tready;
    assign w_expire    = c_REFRESH_EN && (r_state == ST_PAUSED) && (r_timer == c_TMR_LAST);

    // Register the watermark comparisons; the FSM acts on these one cycle later
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_above_hi <= 1'b0;
            r_below_lo <= 1'b0;
        end else begin
            r_above_hi <= (rx_fifo_level >= c_HIGH_WM);
            r_below_lo <= (rx_fifo_level <= c_LOW_WM);
        end
    end

    // Next-state logic; loss of channel overrides everything
    always_comb begin
        w_next_state = r_state;
        if (!channel_up) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:      if (enable) w_next_state = ST_RUN;
                ST_RUN: begin
                    if (!enable)         w_next_state = ST_IDLE;
                    else if (r_above_hi) w_next_state = ST_SEND_XOFF;
                end
                ST_SEND_XOFF: if (w_handshake) w_next_state = ST_PAUSED;
                ST_PAUSED: begin
                    // XON takes precedence over a coincident refresh expiry
                    if (r_below_lo || !enable) w_next_state = ST_SEND_XON;
                    else if (w_expire)         w_next_state = ST_SEND_XOFF;
                end
                ST_SEND_XON:  if (w_handshake) w_next_state = enable ? ST_RUN : ST_IDLE;
                default:      w_next_state = ST_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) r_state <= ST_IDLE;
        else             r_state <= w_next_state;
    end

    // Refresh timer: runs only while paused, zero everywhere else
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n)                               r_timer <= '0;
        else if (c_REFRESH_EN && r_state == ST_PAUSED) r_timer <= r_timer + 1'b1;
        else                                           r_timer <= '0;
    end

    // Registered NFC stream outputs, derived from the upcoming state
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_tvalid <= 1'b0;
            r_tdata  <= 16'h0000;
        end else begin
            r_tvalid <= (w_next_state == ST_SEND_XOFF) || (w_next_state == ST_SEND_XON);
            r_tdata  <= (w_next_state == ST_SEND_XOFF) ? NFC_MSG_XOFF : NFC_MSG_XON;
        end
    end

    // Pause status and accepted-message counter
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_xoff  <= 1'b0;
            r_count <= 16'h0000;
        end else begin
            if (w_handshake) r_count <= r_count + 16'd1;
            if (w_next_state == ST_IDLE)                     r_xoff <= 1'b0;
            else if (w_handshake && r_state == ST_SEND_XOFF) r_xoff <= 1'b1;
            else if (w_handshake && r_state == ST_SEND_XON)  r_xoff <= 1'b0;
        end
    end

    assign m_axi_nfc_tvalid = r_tvalid;
    assign m_axi_nfc_tdata  = r_tdata;
    assign xoff_active      = r_xoff;
    assign nfc_msg_count    = r_count;

endmodule : aurora_nfc_ctrl
`default_nettype wire

// File: tb/tb_aurora_nfc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_aurora_nfc_ctrl
// Description : Directed self-checking bench for aurora_nfc_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aurora_nfc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        cu;
    logic [12:0] lvl;
    logic        rdy;
    logic        tvalid;
    logic [15:0] tdata;
    logic        xoff;
    logic [15:0] cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_count;

    always #5 clk = ~clk;

    aurora_nfc_ctrl #(
        .FIFO_LEVEL_W  (13),
        .HIGH_WM       (3072),
        .LOW_WM        (1024),
        .REFRESH_CYCLES(16)
    ) dut (
        .user_clk        (clk),
        .user_rst_n      (rst_n),
        .enable          (en),
        .channel_up      (cu),
        .rx_fifo_level   (lvl),
        .m_axi_nfc_tvalid(tvalid),
        .m_axi_nfc_tdata (tdata),
        .m_axi_nfc_tready(rdy),
        .xoff_active     (xoff),
        .nfc_msg_count   (cnt)
    );

    typedef struct {
        logic        en;
        logic        cu;
        logic [12:0] lvl;
        logic        rdy;
        logic        tv;
        logic [15:0] td;
        logic        xo;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until tvalid is seen, failing if the budget runs out
    task automatic wait_tvalid(input string name, input int max_cycles);
        int k = 0;
        while (tvalid !== 1'b1 && k < max_cycles) begin
            step();
            k++;
        end
        check({name, "_timeout"}, {31'd0, tvalid}, 32'd1);
    endtask

    initial begin
        int n_hs;
        int last_k;
        logic [15:0] prev;

        //          en    cu    lvl    rdy   tv    td        xo    cnt
        vecs[0] = '{1'b1, 1'b1, 13'd0,    1'b1, 1'b0, 16'h0000, 1'b0, 16'd0};
        vecs[1] = '{1'b1, 1'b1, 13'd3072, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd0};
        vecs[2] = '{1'b1, 1'b1, 13'd3072, 1'b1, 1'b1, 16'h0010, 1'b0, 16'd0};
        vecs[3] = '{1'b1, 1'b1, 13'd1024, 1'b1, 1'b0, 16'h0000, 1'b1, 16'd1};
        vecs[4] = '{1'b1, 1'b1, 13'd1024, 1'b1, 1'b1, 16'h0000, 1'b1, 16'd1};
        vecs[5] = '{1'b1, 1'b1, 13'd1024, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd2};
        vecs[6] = '{1'b1, 1'b1, 13'd500,  1'b1, 1'b0, 16'h0000, 1'b0, 16'd2};

        rst_n = 1'b0; en = 1'b0; cu = 1'b0; lvl = '0; rdy = 1'b0;
        repeat (3) step();
        check("rst_tvalid", {31'd0, tvalid}, 32'd0);
        check("rst_tdata",  {16'd0, tdata},  32'd0);
        check("rst_xoff",   {31'd0, xoff},   32'd0);
        check("rst_count",  {16'd0, cnt},    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Basic ramp: XOFF one cycle after the crossing, then XON
        for (int i = 0; i < 7; i++) begin
            en = vecs[i].en; cu = vecs[i].cu; lvl = vecs[i].lvl; rdy = vecs[i].rdy;
            step();
            check($sformatf("vec%0d_tvalid", i), {31'd0, tvalid}, {31'd0, vecs[i].tv});
            if (vecs[i].tv)
                check($sformatf("vec%0d_tdata", i), {16'd0, tdata}, {16'd0, vecs[i].td});
            check($sformatf("vec%0d_xoff", i), {31'd0, xoff}, {31'd0, vecs[i].xo});
            check($sformatf("vec%0d_count", i), {16'd0, cnt}, {16'd0, vecs[i].cnt});
        end
        exp_count = 16'd2;

        // Back-pressure: pending XOFF stays stable while tready is low
        lvl = 13'd3072; rdy = 1'b0;
        wait_tvalid("bp_xoff", 10);
        for (int i = 0; i < 50; i++) begin
            if (i == 5) lvl = 13'd0;
            step();
            check("bp_hold_tvalid", {31'd0, tvalid}, 32'd1);
            check("bp_hold_tdata",  {16'd0, tdata},  32'h0010);
        end
        rdy = 1'b1;
        step();
        exp_count++;
        check("bp_xoff_acc_tvalid", {31'd0, tvalid}, 32'd0);
        check("bp_xoff_acc_xoff",   {31'd0, xoff},   32'd1);
        check("bp_xoff_acc_count",  {16'd0, cnt},    {16'd0, exp_count});
        step();
        check("bp_xon_tvalid", {31'd0, tvalid}, 32'd1);
        check("bp_xon_tdata",  {16'd0, tdata},  32'h0000);
        step();
        exp_count++;
        check("bp_xon_acc_xoff",  {31'd0, xoff}, 32'd0);
        check("bp_xon_acc_count", {16'd0, cnt},  {16'd0, exp_count});

        // Refresh: XOFF re-sent every 17 cycles while the level stays high
        lvl = 13'd4000;
        wait_tvalid("ref_xoff", 10);
        check("ref_tdata", {16'd0, tdata}, 32'h0010);
        n_hs = 0; last_k = 0; prev = cnt;
        for (int k = 1; k <= 69; k++) begin
            step();
            if (cnt != prev) begin
                n_hs++;
                if (n_hs > 1) check("ref_period", k - last_k, 32'd17);
                last_k = k;
                prev = cnt;
            end
            if (n_hs > 0) check("ref_xoff_held", {31'd0, xoff}, 32'd1);
        end
        exp_count = exp_count + 16'd5;
        check("ref_hs_count", n_hs, 32'd5);
        check("ref_count", {16'd0, cnt}, {16'd0, exp_count});
        lvl = 13'd0;
        wait_tvalid("ref_xon", 10);
        check("ref_xon_tdata", {16'd0, tdata}, 32'h0000);
        step();
        exp_count++;
        check("ref_xon_xoff",  {31'd0, xoff}, 32'd0);
        check("ref_xon_count", {16'd0, cnt},  {16'd0, exp_count});

        // Channel loss while an XOFF is pending drops it without a handshake
        lvl = 13'd3500; rdy = 1'b0;
        wait_tvalid("cl_xoff", 10);
        cu = 1'b0;
        step();
        check("cl_tvalid", {31'd0, tvalid}, 32'd0);
        check("cl_xoff",   {31'd0, xoff},   32'd0);
        check("cl_count",  {16'd0, cnt},    {16'd0, exp_count});
        cu = 1'b1;
        wait_tvalid("cl_reissue", 5);
        check("cl_reissue_tdata", {16'd0, tdata}, 32'h0010);
        rdy = 1'b1;
        step();
        exp_count++;
        check("cl_acc_xoff",  {31'd0, xoff}, 32'd1);
        check("cl_acc_count", {16'd0, cnt},  {16'd0, exp_count});

        // Disable while paused: XON, then idle with no more traffic
        en = 1'b0;
        step();
        check("dis_xon_tvalid", {31'd0, tvalid}, 32'd1);
        check("dis_xon_tdata",  {16'd0, tdata},  32'h0000);
        step();
        exp_count++;
        check("dis_acc_xoff",  {31'd0, xoff}, 32'd0);
        check("dis_acc_count", {16'd0, cnt},  {16'd0, exp_count});
        for (int i = 0; i < 20; i++) begin
            step();
            check("dis_quiet_tvalid", {31'd0, tvalid}, 32'd0);
        end
        check("dis_quiet_count", {16'd0, cnt}, {16'd0, exp_count});

        // Asynchronous reset in the middle of an offered message
        en = 1'b1; rdy = 1'b0;
        wait_tvalid("ar_xoff", 10);
        rdy = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_tvalid", {31'd0, tvalid}, 32'd0);
        check("ar_tdata",  {16'd0, tdata},  32'd0);
        check("ar_xoff",   {31'd0, xoff},   32'd0);
        check("ar_count",  {16'd0, cnt},    32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_aurora_nfc_ctrl
`default_nettype wire
